// File: rtl/gpio_interval_meter.sv
`default_nettype none
// ============================================================================
// Module      : gpio_interval_meter
// Description : Measures the interval, in inclk cycles, between successive
//               rising edges of an asynchronous GPIO toggle. A divided clock
//               (slowclk) is edge-detected in the inclk domain and used only
//               as a coarse timeout timebase. Results leave on a one-deep
//               valid/ready output register.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   inclk       in   1      system clock, all logic on posedge
//   reset       in   1      synchronous, active-high
//   gpio_in     in   1      asynchronous GPIO input
//   slowclk     in   1      divided clock level, edge-detected internally
//   m_valid     out  1      result register holds an unread result
//   m_ready     in   1      consumer accepts when m_valid & m_ready
//   m_count     out  CNT_W  measured interval in inclk cycles
//   m_overflow  out  1      counter saturated during this interval
//   m_timeout   out  1      result produced by timeout, not a gpio edge
//   drop_cnt    out  8      results lost to a full output register (sat.)
//   busy        out  1      high while measuring
// ============================================================================
module gpio_interval_meter #(
  parameter int CNT_W         = 32,
  parameter int SYNC_STAGES   = 2,
  parameter int TIMEOUT_TICKS = 4
) (
  input  logic             inclk,
  input  logic             reset,
  input  logic             gpio_in,
  input  logic             slowclk,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [CNT_W-1:0] m_count,
  output logic             m_overflow,
  output logic             m_timeout,
  output logic [7:0]       drop_cnt,
  output logic             busy
);

  localparam int                TICK_W      = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [CNT_W-1:0]  C_CNT_MAX   = '1;
  localparam logic [TICK_W-1:0] C_TICK_LAST = TICK_W'(TIMEOUT_TICKS - 1);
  localparam logic [7:0]        C_DROP_MAX  = 8'hFF;

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_MEASURE = 1'b1
  } state_t;

  // Synchronisers and edge-detect history
  logic [SYNC_STAGES-1:0] r_gpio_sync;
  logic [SYNC_STAGES-1:0] r_slow_sync;
  logic                   r_gpio_prev;
  logic                   r_slow_prev;
  logic                   w_gpio_rise;
  logic                   w_slow_rise;

  // Measurement state
  state_t                 r_state;
  state_t                 w_state_next;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_next;
  logic                   r_ovf;
  logic                   w_ovf_next;
  logic [TICK_W-1:0]      r_tick;
  logic [TICK_W-1:0]      w_tick_next;
  logic                   w_cnt_max;

  // Result event produced by the FSM this cycle
  logic                   w_res_valid;
  logic [CNT_W-1:0]       w_res_count;
  logic                   w_res_ovf;
  logic                   w_res_timeout;

  // Output register
  logic                   r_m_valid;
  logic [CNT_W-1:0]       r_m_count;
  logic                   r_m_overflow;
  logic                   r_m_timeout;
  logic [7:0]             r_drop_cnt;
  logic                   r_busy;
  logic                   w_load;
  logic                   w_drop;

  // --------------------------------------------------------------------------
  // Synchronisers: the last stage feeds a one-cycle-delayed copy so that a
  // rising edge shows up as a single-cycle pulse in the inclk domain.
  // --------------------------------------------------------------------------
  always_ff @(posedge inclk) begin
    if (reset) begin
      r_gpio_sync <= '0;
      r_slow_sync <= '0;
      r_gpio_prev <= 1'b0;
      r_slow_prev <= 1'b0;
    end else begin
      r_gpio_sync <= {r_gpio_sync[SYNC_STAGES-2:0], gpio_in};
      r_slow_sync <= {r_slow_sync[SYNC_STAGES-2:0], slowclk};
      r_gpio_prev <= r_gpio_sync[SYNC_STAGES-1];
      r_slow_prev <= r_slow_sync[SYNC_STAGES-1];
    end
  end

  assign w_gpio_rise = r_gpio_sync[SYNC_STAGES-1] & ~r_gpio_prev;
  assign w_slow_rise = r_slow_sync[SYNC_STAGES-1] & ~r_slow_prev;
  assign w_cnt_max   = (r_cnt == C_CNT_MAX);

  // --------------------------------------------------------------------------
  // FSM state and measurement registers
  // --------------------------------------------------------------------------
  always_ff @(posedge inclk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      r_tick  <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_ovf   <= w_ovf_next;
      r_tick  <= w_tick_next;
      r_busy  <= (w_state_next == S_MEASURE);
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state and result generation
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_ovf_next    = r_ovf;
    w_tick_next   = r_tick;
    w_res_valid   = 1'b0;
    w_res_count   = r_cnt;
    w_res_ovf     = r_ovf;
    w_res_timeout = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_cnt_next  = '0;
        w_ovf_next  = 1'b0;
        w_tick_next = '0;
        if (w_gpio_rise) begin
          w_state_next = S_MEASURE;
        end
      end

      S_MEASURE: begin
        // Saturating count; the flag remembers any attempt past all-ones
        if (w_cnt_max) begin
          w_ovf_next = 1'b1;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end

        // A gpio edge takes priority over a coincident timeout
        if (w_gpio_rise) begin
          w_res_valid = 1'b1;
          w_res_count = w_cnt_max ? r_cnt : (r_cnt + 1'b1);
          w_res_ovf   = r_ovf;
          w_cnt_next  = '0;
          w_ovf_next  = 1'b0;
          w_tick_next = '0;
        end else if (w_slow_rise) begin
          if (r_tick == C_TICK_LAST) begin
            w_res_valid   = 1'b1;
            w_res_count   = r_cnt;
            w_res_ovf     = r_ovf;
            w_res_timeout = 1'b1;
            w_state_next  = S_IDLE;
            w_cnt_next    = '0;
            w_ovf_next    = 1'b0;
            w_tick_next   = '0;
          end else begin
            w_tick_next = r_tick + 1'b1;
          end
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // One-deep output register. A handshake in the same cycle frees the slot,
  // so a new result can be loaded without a bubble.
  // --------------------------------------------------------------------------
  assign w_load = w_res_valid & (~r_m_valid | m_ready);
  assign w_drop = w_res_valid & ~w_load;

  always_ff @(posedge inclk) begin
    if (reset) begin
      r_m_valid    <= 1'b0;
      r_m_count    <= '0;
      r_m_overflow <= 1'b0;
      r_m_timeout  <= 1'b0;
      r_drop_cnt   <= '0;
    end else begin
      if (w_load) begin
        r_m_valid    <= 1'b1;
        r_m_count    <= w_res_count;
        r_m_overflow <= w_res_ovf;
        r_m_timeout  <= w_res_timeout;
      end else if (m_ready) begin
        r_m_valid <= 1'b0;
      end

      if (w_drop && (r_drop_cnt != C_DROP_MAX)) begin
        r_drop_cnt <= r_drop_cnt + 1'b1;
      end
    end
  end

  assign m_valid    = r_m_valid;
  assign m_count    = r_m_count;
  assign m_overflow = r_m_overflow;
  assign m_timeout  = r_m_timeout;
  assign drop_cnt   = r_drop_cnt;
  assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_gpio_interval_meter.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpio_interval_meter
// Description : Directed self-checking bench for gpio_interval_meter. Two
//               instances share all inputs: one with a 32-bit counter and one
//               with a 4-bit counter for saturation behaviour. Inputs change
//               on the falling edge of inclk; accepted results are logged
//               shortly after each falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpio_interval_meter;

  logic        inclk;
  logic        reset;
  logic        gpio_in;
  logic        slowclk;
  logic        m_ready;

  logic        m_valid;
  logic [31:0] m_count;
  logic        m_overflow;
  logic        m_timeout;
  logic [7:0]  drop_cnt;
  logic        busy;

  logic        m_valid4;
  logic [3:0]  m_count4;
  logic        m_overflow4;
  logic        m_timeout4;
  logic [7:0]  drop_cnt4;
  logic        busy4;

  int n_checks;
  int n_fail;

  // Accepted-result logs
  int          n_res32;
  int          n_res4;
  logic [31:0] log_cnt32 [0:63];
  logic        log_ovf32 [0:63];
  logic        log_to32  [0:63];
  logic [3:0]  log_cnt4  [0:63];
  logic        log_ovf4  [0:63];
  logic        log_to4   [0:63];

  int b32;
  int b4;

  gpio_interval_meter #(
    .CNT_W         (32),
    .SYNC_STAGES   (2),
    .TIMEOUT_TICKS (4)
  ) dut (
    .inclk      (inclk),
    .reset      (reset),
    .gpio_in    (gpio_in),
    .slowclk    (slowclk),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_count    (m_count),
    .m_overflow (m_overflow),
    .m_timeout  (m_timeout),
    .drop_cnt   (drop_cnt),
    .busy       (busy)
  );

  gpio_interval_meter #(
    .CNT_W         (4),
    .SYNC_STAGES   (2),
    .TIMEOUT_TICKS (4)
  ) dut4 (
    .inclk      (inclk),
    .reset      (reset),
    .gpio_in    (gpio_in),
    .slowclk    (slowclk),
    .m_valid    (m_valid4),
    .m_ready    (m_ready),
    .m_count    (m_count4),
    .m_overflow (m_overflow4),
    .m_timeout  (m_timeout4),
    .drop_cnt   (drop_cnt4),
    .busy       (busy4)
  );

  initial inclk = 1'b0;
  always #5 inclk = ~inclk;

  initial begin
    n_res32 = 0;
    n_res4  = 0;
  end

  always @(negedge inclk) begin
    #1;
    if (m_valid && m_ready) begin
      log_cnt32[n_res32 & 63] = m_count;
      log_ovf32[n_res32 & 63] = m_overflow;
      log_to32[n_res32 & 63]  = m_timeout;
      n_res32 = n_res32 + 1;
    end
    if (m_valid4 && m_ready) begin
      log_cnt4[n_res4 & 63] = m_count4;
      log_ovf4[n_res4 & 63] = m_overflow4;
      log_to4[n_res4 & 63]  = m_timeout4;
      n_res4 = n_res4 + 1;
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge inclk);
    reset = 1'b1;
    repeat (3) @(negedge inclk);
    reset = 1'b0;
  endtask

  // Raises gpio_in now; the next call starts exactly n cycles later
  task automatic run_gpio(input int n);
    gpio_in = 1'b1;
    repeat (3) @(negedge inclk);
    gpio_in = 1'b0;
    repeat (n - 3) @(negedge inclk);
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    gpio_in  = 1'b0;
    slowclk  = 1'b0;
    m_ready  = 1'b1;

    // Reset state and quiet input
    do_reset();
    check_val("rst_count", m_count, 0);
    check_val("rst_ovf", m_overflow, 0);
    check_val("rst_timeout", m_timeout, 0);
    for (int i = 0; i < 10; i++) begin
      repeat (10) @(negedge inclk);
      check_val("idle_valid", m_valid, 0);
      check_val("idle_busy", busy, 0);
      check_val("idle_drop", drop_cnt, 0);
    end

    // Rises at 10, 110, 160 -> 100 then 50
    do_reset();
    b32 = n_res32;
    b4  = n_res4;
    run_gpio(100);
    run_gpio(50);
    run_gpio(20);
    check_val("basic_nres", n_res32 - b32, 2);
    check_val("basic_cnt0", log_cnt32[b32 & 63], 100);
    check_val("basic_ovf0", log_ovf32[b32 & 63], 0);
    check_val("basic_to0", log_to32[b32 & 63], 0);
    check_val("basic_cnt1", log_cnt32[(b32 + 1) & 63], 50);
    check_val("basic_ovf1", log_ovf32[(b32 + 1) & 63], 0);
    check_val("basic_to1", log_to32[(b32 + 1) & 63], 0);
    check_val("basic_busy", busy, 1);
    check_val("basic_valid_after", m_valid, 0);
    check_val("basic4_cnt0", log_cnt4[b4 & 63], 15);
    check_val("basic4_ovf0", log_ovf4[b4 & 63], 1);

    // Saturation with a 4-bit counter: 40 then 10
    do_reset();
    b32 = n_res32;
    b4  = n_res4;
    run_gpio(40);
    run_gpio(10);
    run_gpio(10);
    check_val("sat_nres", n_res4 - b4, 2);
    check_val("sat_cnt0", log_cnt4[b4 & 63], 15);
    check_val("sat_ovf0", log_ovf4[b4 & 63], 1);
    check_val("sat_to0", log_to4[b4 & 63], 0);
    check_val("sat_cnt1", log_cnt4[(b4 + 1) & 63], 10);
    check_val("sat_ovf1", log_ovf4[(b4 + 1) & 63], 0);
    check_val("wide_cnt0", log_cnt32[b32 & 63], 40);
    check_val("wide_ovf0", log_ovf32[b32 & 63], 0);

    // Timeout: one rise, then four slowclk rising edges 8 cycles apart.
    // Measurement starts 3 cycles after gpio_in rises; the first slowclk edge
    // acts 6 cycles after, the fourth at 30, when the counter holds 26.
    do_reset();
    b32 = n_res32;
    b4  = n_res4;
    gpio_in = 1'b1;
    repeat (3) @(negedge inclk);
    gpio_in = 1'b0;
    for (int t = 0; t < 4; t++) begin
      slowclk = 1'b1;
      repeat (4) @(negedge inclk);
      slowclk = 1'b0;
      repeat (4) @(negedge inclk);
    end
    check_val("to_nres", n_res32 - b32, 1);
    check_val("to_cnt", log_cnt32[b32 & 63], 26);
    check_val("to_flag", log_to32[b32 & 63], 1);
    check_val("to_ovf", log_ovf32[b32 & 63], 0);
    check_val("to_busy", busy, 0);
    check_val("to4_cnt", log_cnt4[b4 & 63], 15);
    check_val("to4_ovf", log_ovf4[b4 & 63], 1);
    check_val("to4_flag", log_to4[b4 & 63], 1);
    b32 = n_res32;
    run_gpio(20);
    check_val("to_restart_busy", busy, 1);
    check_val("to_restart_nres", n_res32 - b32, 0);

    // Back-pressure: three intervals with m_ready low
    do_reset();
    m_ready = 1'b0;
    run_gpio(30);
    run_gpio(40);
    run_gpio(50);
    run_gpio(10);
    check_val("bp_valid", m_valid, 1);
    check_val("bp_cnt", m_count, 30);
    check_val("bp_drop", drop_cnt, 2);
    check_val("bp_timeout", m_timeout, 0);
    b32 = n_res32;
    m_ready = 1'b1;
    @(negedge inclk);
    check_val("bp_accept_nres", n_res32 - b32, 1);
    check_val("bp_accept_cnt", log_cnt32[b32 & 63], 30);
    check_val("bp_valid_clr", m_valid, 0);

    // Reset in the middle of an interval
    do_reset();
    m_ready = 1'b0;
    run_gpio(30);
    run_gpio(30);
    run_gpio(13);
    check_val("mid_pre_valid", m_valid, 1);
    check_val("mid_pre_drop", drop_cnt, 1);
    check_val("mid_pre_busy", busy, 1);
    do_reset();
    check_val("mid_valid", m_valid, 0);
    check_val("mid_cnt", m_count, 0);
    check_val("mid_ovf", m_overflow, 0);
    check_val("mid_to", m_timeout, 0);
    check_val("mid_drop", drop_cnt, 0);
    check_val("mid_busy", busy, 0);
    run_gpio(20);
    check_val("mid_restart_busy", busy, 1);
    check_val("mid_restart_valid", m_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
